// File: rtl/uart_sim_monitor.sv
// uart_sim_monitor: simulation-side 8N1 UART receiver with a byte FIFO and pass-pattern detector.
//   clk_i        system clock
//   rst_ni       synchronous active-low reset
//   uart_tx_i    serial line from the DUT, idle high
//   rd_i         pop the FIFO head
//   rd_data_o    FIFO head byte, valid while rd_valid_o is high
//   rd_valid_o   FIFO not empty
//   overflow_o   sticky: a received byte was dropped because the FIFO was full
//   frame_err_o  sticky: a stop bit was sampled low
//   match_o      sticky: PATTERN appeared in the well-framed byte stream
//   byte_count_o well-framed byte count, saturating
module uart_sim_monitor #(
    parameter int unsigned          CLKS_PER_BIT = 868,
    parameter int unsigned          FIFO_DEPTH   = 16,
    parameter int unsigned          PAT_LEN      = 4,
    parameter logic [8*PAT_LEN-1:0] PATTERN      = "PASS"
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        uart_tx_i,
    input  logic        rd_i,
    output logic [7:0]  rd_data_o,
    output logic        rd_valid_o,
    output logic        overflow_o,
    output logic        frame_err_o,
    output logic        match_o,
    output logic [15:0] byte_count_o
);

    localparam int unsigned HALF_BIT  = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W     = $clog2(CLKS_PER_BIT);
    localparam int unsigned AW        = $clog2(FIFO_DEPTH);
    localparam int unsigned PW        = AW + 1;
    localparam int unsigned IDX_W     = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;
    localparam logic [7:0]  PAT_FIRST = PATTERN[8*(PAT_LEN-1) +: 8];

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    // Input synchronizer plus one extra stage for falling-edge detection
    logic rx_meta_q, rxs_q, rxs_prev_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rx_meta_q  <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
        end else begin
            rx_meta_q  <= uart_tx_i;
            rxs_q      <= rx_meta_q;
            rxs_prev_q <= rxs_q;
        end
    end

    // Receive FSM state register and datapath registers
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             byte_ok_c, frame_bad_c;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    // Next-state logic; byte_ok_c / frame_bad_c pulse in the stop-sample cycle
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        byte_ok_c   = 1'b0;
        frame_bad_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rxs_prev_q && !rxs_q) begin
                    state_d = S_START;
                    cnt_d   = '0;
                    bit_d   = '0;
                end
            end
            S_START: begin
                if (cnt_q == CNT_W'(HALF_BIT - 1)) begin
                    cnt_d   = '0;
                    state_d = rxs_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                    cnt_d   = '0;
                    shift_d = {rxs_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                    cnt_d = '0;
                    if (rxs_q) begin
                        byte_ok_c = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        frame_bad_c = 1'b1;
                        state_d     = S_WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT_HIGH: begin
                // Hold off until the line is released so a break is not decoded as 0x00 frames
                if (rxs_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FIFO with extra pointer MSB for full/empty; head byte kept in a register
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d, rd_ptr_inc_c;
    logic [7:0]    rd_data_d;
    logic          full_c, pop_c, push_c;

    assign full_c       = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                          (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_c        = rd_i && rd_valid_o;
    assign push_c       = byte_ok_c && (!full_c || pop_c);
    assign rd_ptr_inc_c = rd_ptr_q + PW'(1);

    // Next head: the entry behind the popped one, or the incoming byte when it lands at the head
    always_comb begin
        wr_ptr_d  = push_c ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
        rd_ptr_d  = pop_c ? rd_ptr_inc_c : rd_ptr_q;
        rd_data_d = rd_data_o;
        if (pop_c) begin
            if (rd_ptr_inc_c != wr_ptr_q) begin
                rd_data_d = mem_q[rd_ptr_inc_c[AW-1:0]];
            end else if (push_c) begin
                rd_data_d = shift_q;
            end
        end else if (!rd_valid_o && push_c) begin
            rd_data_d = shift_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_c) begin
            mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rd_data_o  <= '0;
            rd_valid_o <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_data_o  <= rd_data_d;
            rd_valid_o <= (wr_ptr_d != rd_ptr_d);
        end
    end

    // Pattern byte expected at the current match index
    logic [IDX_W-1:0] idx_q;
    logic [7:0]       pat_byte_c;

    always_comb begin
        pat_byte_c = PAT_FIRST;
        for (int unsigned i = 0; i < PAT_LEN; i++) begin
            if (idx_q == IDX_W'(i)) begin
                pat_byte_c = PATTERN[8*(PAT_LEN-1-i) +: 8];
            end
        end
    end

    // Sticky flags, byte counter and matcher; all see dropped bytes as well
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            overflow_o   <= 1'b0;
            frame_err_o  <= 1'b0;
            match_o      <= 1'b0;
            byte_count_o <= '0;
            idx_q        <= '0;
        end else begin
            if (frame_bad_c) begin
                frame_err_o <= 1'b1;
            end
            if (byte_ok_c) begin
                if (full_c && !pop_c) begin
                    overflow_o <= 1'b1;
                end
                if (byte_count_o != 16'hFFFF) begin
                    byte_count_o <= byte_count_o + 16'd1;
                end
                if (shift_q == pat_byte_c) begin
                    if (idx_q == IDX_W'(PAT_LEN - 1)) begin
                        match_o <= 1'b1;
                        idx_q   <= '0;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end else begin
                    idx_q <= (shift_q == PAT_FIRST) ? IDX_W'(1) : '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_sim_monitor.sv
// tb_uart_sim_monitor: self-checking bench for uart_sim_monitor (8 clks/bit, 4-deep FIFO, pattern "OK").
module tb_uart_sim_monitor;

    localparam int          CPB   = 8;
    localparam int          DEPTH = 4;
    localparam int          PLEN  = 2;
    localparam logic [15:0] PAT   = "OK";
    // Loop index of the stop-sample cycle, counted in negedges from the start-bit drive
    localparam int          PUSH_C = 9*CPB + CPB/2 + 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tx = 1'b1;
    logic        rd = 1'b0;
    logic [7:0]  rd_data;
    logic        rd_valid, ovf, ferr, match;
    logic [15:0] cnt;

    always #5 clk = ~clk;

    uart_sim_monitor #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH),
        .PAT_LEN     (PLEN),
        .PATTERN     (PAT)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .uart_tx_i   (tx),
        .rd_i        (rd),
        .rd_data_o   (rd_data),
        .rd_valid_o  (rd_valid),
        .overflow_o  (ovf),
        .frame_err_o (ferr),
        .match_o     (match),
        .byte_count_o(cnt)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame-level reference model: byte queue, sticky flags, suffix match on the good-byte stream
    logic [7:0] mq[$];
    logic [7:0] hist[$];
    int         m_cnt;
    bit         m_ovf, m_ferr, m_match;

    function automatic void model_reset();
        mq.delete();
        hist.delete();
        m_cnt   = 0;
        m_ovf   = 1'b0;
        m_ferr  = 1'b0;
        m_match = 1'b0;
    endfunction

    function automatic void model_frame(input logic [7:0] b, input bit good, input bit pop);
        bit hit;
        if (pop && mq.size() > 0) void'(mq.pop_front());
        if (!good) begin
            m_ferr = 1'b1;
            return;
        end
        if (mq.size() < DEPTH) mq.push_back(b);
        else m_ovf = 1'b1;
        if (m_cnt < 65535) m_cnt++;
        hist.push_back(b);
        if (hist.size() > PLEN) void'(hist.pop_front());
        if (hist.size() == PLEN) begin
            hit = 1'b1;
            for (int i = 0; i < PLEN; i++)
                if (hist[i] != PAT[8*(PLEN-1-i) +: 8]) hit = 1'b0;
            if (hit) m_match = 1'b1;
        end
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, ".valid"}, rd_valid, mq.size() > 0);
        if (mq.size() > 0) check({tag, ".head"}, rd_data, mq[0]);
        check({tag, ".count"}, cnt, m_cnt);
        check({tag, ".ovf"}, ovf, m_ovf);
        check({tag, ".ferr"}, ferr, m_ferr);
        check({tag, ".match"}, match, m_match);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tx    = 1'b1;
        rd    = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
    endtask

    // Send one 8N1 frame starting at a negedge. Optional rd pulse exactly on the push edge,
    // optional cycle-exact check of the output update. A bad frame leaves the line low for
    // three more bit times, then idles high for one bit time.
    task automatic send_frame(input logic [7:0] b, input bit good, input bit pop_at_push,
                              input bit chk_timing);
        logic [9:0] bits;
        bits = {good, b, 1'b0};
        for (int c = 0; c < 10*CPB; c++) begin
            if (c == PUSH_C) begin
                if (chk_timing) begin
                    check("pre_push.valid", rd_valid, mq.size() > 0);
                    check("pre_push.count", cnt, m_cnt);
                end
                if (pop_at_push && mq.size() > 0) check("push_pop.head", rd_data, mq[0]);
                rd = pop_at_push;
            end else if (c == PUSH_C + 1) begin
                rd = 1'b0;
                model_frame(b, good, pop_at_push);
                if (chk_timing) check_outputs("post_push");
            end
            tx = bits[c / CPB];
            @(negedge clk);
        end
        tx = 1'b1;
        if (!good) begin
            tx = 1'b0;
            repeat (3*CPB) @(negedge clk);
            tx = 1'b1;
            repeat (CPB) @(negedge clk);
        end
    endtask

    task automatic pop_one(input string tag);
        if (mq.size() > 0) check({tag, ".pop_data"}, rd_data, mq[0]);
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        if (mq.size() > 0) void'(mq.pop_front());
    endtask

    typedef struct {
        logic [7:0]  data;
        bit          good;
        int          pops;
        logic        exp_valid;
        logic [7:0]  exp_head;
        logic [15:0] exp_cnt;
        logic        exp_match;
        logic        exp_ovf;
        logic        exp_ferr;
    } vec_t;

    vec_t tbl[8];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        logic [9:0] pbits;
        bit         good, pap;
        int         npops, gap;

        tbl[0] = '{8'hA5, 1'b1, 0, 1'b1, 8'hA5, 16'd1, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{8'h78, 1'b1, 1, 1'b1, 8'h78, 16'd2, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{8'h4F, 1'b1, 0, 1'b1, 8'h78, 16'd3, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{8'h4B, 1'b1, 0, 1'b1, 8'h78, 16'd4, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{8'h01, 1'b1, 0, 1'b1, 8'h78, 16'd5, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{8'h02, 1'b1, 0, 1'b1, 8'h78, 16'd6, 1'b1, 1'b1, 1'b0};
        tbl[6] = '{8'h3C, 1'b0, 0, 1'b1, 8'h78, 16'd6, 1'b1, 1'b1, 1'b1};
        tbl[7] = '{8'h55, 1'b1, 2, 1'b1, 8'h4B, 16'd7, 1'b1, 1'b1, 1'b1};

        // Reset values
        do_reset();
        check("rst.data", rd_data, 8'h00);
        check("rst.valid", rd_valid, 1'b0);
        check("rst.ovf", ovf, 1'b0);
        check("rst.ferr", ferr, 1'b0);
        check("rst.match", match, 1'b0);
        check("rst.count", cnt, 16'd0);

        // Table of frames with hand-derived expectations
        for (int i = 0; i < 8; i++) begin
            for (int p = 0; p < tbl[i].pops; p++) pop_one($sformatf("tbl%0d", i));
            send_frame(tbl[i].data, tbl[i].good, 1'b0, 1'b0);
            check($sformatf("tbl%0d.valid", i), rd_valid, tbl[i].exp_valid);
            check($sformatf("tbl%0d.head", i), rd_data, tbl[i].exp_head);
            check($sformatf("tbl%0d.count", i), cnt, tbl[i].exp_cnt);
            check($sformatf("tbl%0d.match", i), match, tbl[i].exp_match);
            check($sformatf("tbl%0d.ovf", i), ovf, tbl[i].exp_ovf);
            check($sformatf("tbl%0d.ferr", i), ferr, tbl[i].exp_ferr);
        end

        // Overflow: six back-to-back bytes, no pops, then drain
        do_reset();
        for (int i = 1; i <= 6; i++) send_frame(8'(i), 1'b1, 1'b0, 1'b0);
        check("ovf6.count", cnt, 16'd6);
        check("ovf6.ovf", ovf, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("ovf6.drain%0d", i), rd_data, 8'(i));
            pop_one("ovf6");
        end
        check("ovf6.empty", rd_valid, 1'b0);

        // Exact push timing into an empty FIFO, then push+pop while full
        do_reset();
        send_frame(8'h10, 1'b1, 1'b0, 1'b1);
        for (int i = 1; i <= 3; i++) send_frame(8'(8'h10 + i), 1'b1, 1'b0, 1'b0);
        send_frame(8'h14, 1'b1, 1'b1, 1'b1);
        check("fullpp.ovf", ovf, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("fullpp.drain%0d", i), rd_data, 8'(8'h10 + i));
            pop_one("fullpp");
        end
        check("fullpp.empty", rd_valid, 1'b0);
        // Push and rd_i together on an empty FIFO: the push lands
        send_frame(8'h66, 1'b1, 1'b1, 1'b1);
        check("emptypp.head", rd_data, 8'h66);

        // Short low glitch on the idle line, then a real frame
        do_reset();
        tx = 1'b0;
        repeat (2) @(negedge clk);
        tx = 1'b1;
        repeat (CPB/2 + 8) @(negedge clk);
        check_outputs("glitch");
        send_frame(8'hC3, 1'b1, 1'b0, 1'b0);
        check_outputs("after_glitch");

        // Reset during data bit 4, then a clean frame
        send_frame(8'h12, 1'b1, 1'b0, 1'b0);
        pbits = {1'b1, 8'h34, 1'b0};
        for (int c = 0; c < 5*CPB + 4; c++) begin
            tx = pbits[c / CPB];
            @(negedge clk);
        end
        do_reset();
        check("midrst.data", rd_data, 8'h00);
        check_outputs("midrst");
        send_frame(8'h81, 1'b1, 1'b0, 1'b0);
        check("midrst.rx81", rd_data, 8'h81);
        check_outputs("midrst_rx");

        // Randomized frames against the reference model
        do_reset();
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 3))
                0:       b = 8'h4F;
                1:       b = 8'h4B;
                default: b = 8'($urandom_range(0, 255));
            endcase
            good  = ($urandom_range(0, 9) != 0);
            pap   = ($urandom_range(0, 4) == 0);
            npops = int'($urandom_range(0, 2));
            gap   = int'($urandom_range(0, 12));
            for (int p = 0; p < npops; p++) pop_one($sformatf("rnd%0d", n));
            send_frame(b, good, pap, 1'b0);
            check_outputs($sformatf("rnd%0d", n));
            repeat (gap) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
